cpu_alu: RTL and testbench

- Registered arithmetic unit used by the CPU datapath. Supports ADD, SUB, MUL and DIV on unsigned WIDTH-bit operands.
- ADD, SUB and MUL complete in one cycle. DIV is an iterative restoring divider taking WIDTH cycles.
- Produces a registered result plus status flags, with a start/valid/busy handshake toward the CPU control FSM.

---
 rtl/cpu_alu.sv | 156 +++++++++++++++
 tb/tb_cpu_alu.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// Registered unsigned ALU: single-cycle ADD/SUB/MUL and a WIDTH-cycle restoring
// divider, with a start/valid/busy handshake toward the CPU control FSM.
module cpu_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             valid,
  output logic             busy,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV_RUN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic               valid_reg, valid_next;
  logic               carry_reg, carry_next;
  logic               zero_reg, zero_next;
  logic               dbz_reg, dbz_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   dvs_reg, dvs_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_sh;
  logic               fits;
  logic [WIDTH-1:0]   rem_step, quo_step;

  assign sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff = {1'b0, alu_a} - {1'b0, alu_b};
  assign prod = alu_a * alu_b;

  // One restoring step. The shifted remainder needs an extra bit for the compare,
  // but the difference always fits back into WIDTH bits because it is below the divisor.
  assign rem_sh   = {rem_reg, quo_reg[WIDTH-1]};
  assign fits     = (rem_sh >= {1'b0, dvs_reg});
  assign rem_step = fits ? (rem_sh[WIDTH-1:0] - dvs_reg) : rem_sh[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], fits};

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    valid_next = 1'b0;
    carry_next = carry_reg;
    zero_next  = zero_reg;
    dbz_next   = dbz_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dvs_next   = dvs_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          case (alu_sel)
            2'b00: begin
              out_next   = sum[WIDTH-1:0];
              carry_next = sum[WIDTH];
              dbz_next   = 1'b0;
              valid_next = 1'b1;
            end
            2'b01: begin
              out_next   = diff[WIDTH-1:0];
              carry_next = diff[WIDTH];
              dbz_next   = 1'b0;
              valid_next = 1'b1;
            end
            2'b10: begin
              out_next   = prod[WIDTH-1:0];
              carry_next = |prod[2*WIDTH-1:WIDTH];
              dbz_next   = 1'b0;
              valid_next = 1'b1;
            end
            default: begin
              if (alu_b == '0) begin
                out_next   = '1;
                carry_next = 1'b0;
                dbz_next   = 1'b1;
                valid_next = 1'b1;
              end else begin
                state_next = DIV_RUN;
                rem_next   = '0;
                quo_next   = alu_a;
                dvs_next   = alu_b;
                cnt_next   = CNT_W'(WIDTH);
              end
            end
          endcase
        end
      end

      DIV_RUN: begin
        rem_next = rem_step;
        quo_next = quo_step;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          out_next   = quo_step;
          carry_next = 1'b0;
          dbz_next   = 1'b0;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    if (valid_next) zero_next = (out_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      dbz_reg   <= dbz_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dvs_reg   <= dvs_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign alu_out     = out_reg;
  assign valid       = valid_reg;
  assign busy        = (state_reg == DIV_RUN);
  assign carry       = carry_reg;
  assign zero        = zero_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed bench for cpu_alu (WIDTH=4) with hand-computed expected values.
module tb_cpu_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   alu_sel = 2'b00;
  logic [W-1:0] alu_a = '0;
  logic [W-1:0] alu_b = '0;
  logic [W-1:0] alu_out;
  logic         valid, busy, carry, zero, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_sel(alu_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .valid(valid),
    .busy(busy), .carry(carry), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then drop start.
  task automatic issue(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alu_sel = sel; alu_a = a; alu_b = b;
    tick();
    start = 1'b0;
  endtask

  // Result of a completed op, then confirm valid drops and the result holds.
  task automatic expect_result(input string tag, input logic [W-1:0] o, input logic c,
                               input logic z, input logic d);
    $display("op %s -> out=%0d carry=%0b zero=%0b dbz=%0b valid=%0b busy=%0b",
             tag, alu_out, carry, zero, div_by_zero, valid, busy);
    check({tag, ".valid"}, valid, 1);
    check({tag, ".out"}, alu_out, o);
    check({tag, ".carry"}, carry, c);
    check({tag, ".zero"}, zero, z);
    check({tag, ".dbz"}, div_by_zero, d);
    check({tag, ".busy"}, busy, 0);
    tick();
    check({tag, ".valid_drop"}, valid, 0);
    check({tag, ".hold"}, alu_out, o);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.out", alu_out, 0);
    check("rst.flags", {valid, busy, carry, zero, div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b00, 4'd9, 4'd8); expect_result("add_9_8", 4'd1, 1'b1, 1'b0, 1'b0);
    issue(2'b00, 4'd0, 4'd0); expect_result("add_0_0", 4'd0, 1'b0, 1'b1, 1'b0);
    issue(2'b01, 4'd3, 4'd5); expect_result("sub_3_5", 4'd14, 1'b1, 1'b0, 1'b0);
    issue(2'b01, 4'd5, 4'd5); expect_result("sub_5_5", 4'd0, 1'b0, 1'b1, 1'b0);
    issue(2'b10, 4'd5, 4'd4); expect_result("mul_5_4", 4'd4, 1'b1, 1'b0, 1'b0);
    issue(2'b10, 4'd3, 4'd3); expect_result("mul_3_3", 4'd9, 1'b0, 1'b0, 1'b0);

    // DIV 13/3 with an ADD request held through the busy window and the return edge
    issue(2'b11, 4'd13, 4'd3);
    check("div.busy_n", busy, 1);
    check("div.valid_n", valid, 0);
    @(negedge clk);
    start = 1'b1; alu_sel = 2'b00; alu_a = 4'd1; alu_b = 4'd1;
    for (int i = 1; i < W; i++) begin
      tick();
      check($sformatf("div.busy_%0d", i), busy, 1);
      check($sformatf("div.valid_%0d", i), valid, 0);
      check($sformatf("div.out_%0d", i), alu_out, 9);
    end
    tick();
    start = 1'b0;
    expect_result("div_13_3", 4'd4, 1'b0, 1'b0, 1'b0);

    issue(2'b11, 4'd7, 4'd0); expect_result("div_7_0", 4'd15, 1'b0, 1'b0, 1'b1);
    issue(2'b00, 4'd2, 4'd2); expect_result("add_2_2", 4'd4, 1'b0, 1'b0, 1'b0);

    // Back-to-back single-cycle ops with start held high
    @(negedge clk);
    start = 1'b1; alu_sel = 2'b00; alu_a = 4'd1; alu_b = 4'd2;
    tick();
    check("b2b.valid0", valid, 1);
    check("b2b.out0", alu_out, 3);
    alu_sel = 2'b01; alu_a = 4'd7; alu_b = 4'd1;
    tick();
    start = 1'b0;
    $display("op b2b add_1_2 then sub_7_1 -> out=%0d valid=%0b", alu_out, valid);
    check("b2b.valid1", valid, 1);
    check("b2b.out1", alu_out, 6);
    tick();
    check("b2b.valid_drop", valid, 0);

    // Reset mid-DIV
    issue(2'b11, 4'd13, 4'd3);
    tick();
    tick();
    check("mid.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    $display("op reset_mid_div -> out=%0d busy=%0b valid=%0b", alu_out, busy, valid);
    check("mid.out", alu_out, 0);
    check("mid.flags", {valid, busy, carry, zero, div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      tick();
      check($sformatf("mid.no_valid_%0d", i), valid, 0);
    end
    issue(2'b00, 4'd1, 4'd1); expect_result("add_1_1", 4'd2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
